// File: rtl/key_pkg.sv
// Shared definitions for the key capture front end: key count, FSM states
// and the small bit-selection helpers used by the capture logic.
package key_pkg;

    localparam int N_KEYS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2,
        ST_RSVD  = 2'd3
    } key_state_e;

    // Isolate the lowest set bit (x & -x).
    function automatic logic [N_KEYS-1:0] lowest_bit(input logic [N_KEYS-1:0] x);
        return x & (~x + 1'b1);
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something.
    function automatic logic more_than_one(input logic [N_KEYS-1:0] x);
        return (x & (x - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-line debouncer: the output follows the synchronised input only after
// the input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d_sync,
    output logic q
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Count consecutive disagreeing cycles; flip the debounced state on the last one.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (d_sync != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = d_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and debounced state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign q = deb_q;

endmodule

// File: rtl/key_onehot_capture.sv
// Key front end for the 8:3 encoder: synchronise and debounce eight raw key
// lines, capture the lowest-index pressed key as a one-hot word with valid,
// hold it until acknowledged, then wait for full release before re-arming.
module key_onehot_capture
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              ack,
    output logic [N_KEYS-1:0] onehot,
    output logic              valid,
    output logic              multi_err
);

    logic [N_KEYS-1:0] s1_q, s2_q;
    logic [N_KEYS-1:0] deb;

    // The priority select and popcount are registered before the FSM so the
    // capture decision sees a clean flop-to-flop path from the debouncers.
    logic [N_KEYS-1:0] sel_onehot_q, sel_onehot_d;
    logic              sel_multi_q, sel_multi_d;
    logic              sel_any_q, sel_any_d;

    key_state_e        state_q, state_d;
    logic [N_KEYS-1:0] onehot_q, onehot_d;
    logic              valid_q, valid_d;
    logic              multi_err_q, multi_err_d;

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= key_raw;
            s2_q <= s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_deb
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .d_sync(s2_q[gi]),
                .q     (deb[gi])
            );
        end
    endgenerate

    // Lowest-bit select and multi-key detect on the debounced word.
    always_comb begin
        sel_onehot_d = lowest_bit(deb);
        sel_multi_d  = more_than_one(deb);
        sel_any_d    = (deb != '0);
    end

    // Registered select results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_onehot_q <= '0;
            sel_multi_q  <= 1'b0;
            sel_any_q    <= 1'b0;
        end else begin
            sel_onehot_q <= sel_onehot_d;
            sel_multi_q  <= sel_multi_d;
            sel_any_q    <= sel_any_d;
        end
    end

    // Capture FSM next state and outputs; en low overrides everything, including ack.
    always_comb begin
        state_d     = state_q;
        onehot_d    = onehot_q;
        valid_d     = valid_q;
        multi_err_d = multi_err_q;
        if (!en) begin
            state_d     = IDLE;
            onehot_d    = '0;
            valid_d     = 1'b0;
            multi_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    onehot_d    = '0;
                    valid_d     = 1'b0;
                    multi_err_d = 1'b0;
                    if (sel_any_q) begin
                        onehot_d    = sel_onehot_q;
                        multi_err_d = sel_multi_q;
                        valid_d     = 1'b1;
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        onehot_d    = '0;
                        valid_d     = 1'b0;
                        multi_err_d = 1'b0;
                        state_d     = WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    onehot_d    = '0;
                    valid_d     = 1'b0;
                    multi_err_d = 1'b0;
                    if (!sel_any_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    onehot_d    = '0;
                    valid_d     = 1'b0;
                    multi_err_d = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            onehot_q    <= '0;
            valid_q     <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            onehot_q    <= onehot_d;
            valid_q     <= valid_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign onehot    = onehot_q;
    assign valid     = valid_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed and randomized checks of key_onehot_capture against a cycle-level
// behavioural reference model.
module tb_key_onehot_capture;

    localparam int D = 4;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] key_raw = 8'h00;
    logic       ack = 1'b0;
    logic [7:0] onehot;
    logic       valid;
    logic       multi_err;

    int tests = 0;
    int fails = 0;

    key_onehot_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .key_raw  (key_raw),
        .ack      (ack),
        .onehot   (onehot),
        .valid    (valid),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_s1, m_s2, m_deb, m_seen;
    int         m_run [8];
    bit         m_holding, m_waiting;
    logic [7:0] m_onehot;
    logic       m_valid, m_multi;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_seen = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_holding = 0; m_waiting = 0;
        m_onehot = 0; m_valid = 0; m_multi = 0;
    endfunction

    function automatic logic [7:0] lowest_key(input logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[i]) return 8'(1 << i);
        return 8'h00;
    endfunction

    // One clock edge; everything is computed from pre-edge values (later stages first).
    function automatic void model_step();
        // capture logic sees the debounced word one stage late (m_seen)
        if (!en) begin
            m_holding = 0; m_waiting = 0;
            m_onehot = 0; m_valid = 0; m_multi = 0;
        end else if (m_holding) begin
            if (ack) begin
                m_holding = 0; m_waiting = 1;
                m_onehot = 0; m_valid = 0; m_multi = 0;
            end
        end else if (m_waiting) begin
            if (m_seen == 0) m_waiting = 0;
        end else if (m_seen != 0) begin
            m_onehot = lowest_key(m_seen);
            m_multi  = ($countones(m_seen) > 1);
            m_valid  = 1;
            m_holding = 1;
        end
        m_seen = m_deb;
        for (int i = 0; i < 8; i++) begin
            int run_new;
            run_new = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
            if (run_new == D) begin
                m_deb[i] = m_s2[i];
                m_run[i] = 0;
            end else begin
                m_run[i] = run_new;
            end
        end
        m_s2 = m_s1;
        m_s1 = key_raw;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare outputs with the model at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("valid", {7'b0, valid}, {7'b0, m_valid});
        chk("onehot", onehot, m_onehot);
        chk("multi_err", {7'b0, multi_err}, {7'b0, m_multi});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Inputs were just changed; valid must stay low for edges 0..LAT-1 and rise at edge LAT.
    task automatic expect_latency(input string tag);
        for (int e = 0; e <= LAT; e++) begin
            tick();
            chk(tag, {7'b0, valid}, (e == LAT) ? 8'h01 : 8'h00);
        end
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("valid_timeout", {7'b0, valid}, 8'h01);
    endtask

    function automatic logic [7:0] encode(input logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[i]) return 8'(i);
        return 8'h00;
    endfunction

    initial begin
        // Reset
        model_reset();
        rst = 1'b1;
        #12;
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_onehot", onehot, 8'h00);
        chk("rst_multi", {7'b0, multi_err}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        ticks(2);

        // Single press
        en = 1'b1;
        key_raw = 8'h10;
        expect_latency("single_lat");
        chk("single_onehot", onehot, 8'h10);
        chk("single_multi", {7'b0, multi_err}, 8'h00);
        chk("single_enc", encode(onehot), 8'h04);

        // Handshake: ack clears next edge, held key does not recapture
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_valid", {7'b0, valid}, 8'h00);
        chk("ack_onehot", onehot, 8'h00);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("held_no_recap", {7'b0, valid}, 8'h00);
        end
        key_raw = 8'h00;
        ticks(10);
        key_raw = 8'h80;
        wait_valid(20);
        chk("press80_onehot", onehot, 8'h80);
        ack = 1'b1; tick(); ack = 1'b0;
        key_raw = 8'h00;
        ticks(10);

        // Bounce: 3 high, 1 low, then held
        key_raw = 8'h04; ticks(3);
        key_raw = 8'h00; tick();
        key_raw = 8'h04;
        expect_latency("bounce_lat");
        chk("bounce_onehot", onehot, 8'h04);
        ack = 1'b1; tick(); ack = 1'b0;
        key_raw = 8'h00;
        ticks(10);

        // Multi-key
        key_raw = 8'h88;
        wait_valid(20);
        chk("multi_onehot", onehot, 8'h08);
        chk("multi_err", {7'b0, multi_err}, 8'h01);
        ack = 1'b1; tick(); ack = 1'b0;
        key_raw = 8'h08;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("multi_partial_rel", {7'b0, valid}, 8'h00);
        end
        key_raw = 8'h00;
        ticks(10);
        chk("multi_released", {7'b0, valid}, 8'h00);

        // en/ack race in HOLD
        key_raw = 8'h01;
        wait_valid(20);
        chk("race_pre_onehot", onehot, 8'h01);
        en = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("race_valid", {7'b0, valid}, 8'h00);
        chk("race_onehot", onehot, 8'h00);
        en = 1'b1;
        tick();
        chk("race_recap", {7'b0, valid}, 8'h01);
        chk("race_recap_onehot", onehot, 8'h01);

        // Asynchronous reset while holding
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", {7'b0, valid}, 8'h00);
        chk("arst_onehot", onehot, 8'h00);
        #1 rst = 1'b0;
        expect_latency("arst_lat");
        chk("arst_onehot_back", onehot, 8'h01);
        ack = 1'b1; tick(); ack = 1'b0;
        key_raw = 8'h00;
        ticks(10);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: key_raw = 8'h00;
                    1: key_raw = 8'(1 << $urandom_range(0, 7));
                    default: key_raw = 8'($urandom);
                endcase
            end
            ack = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 24) != 0);
            tick();
        end
        ack = 1'b0;
        en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
